mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: data-memory bus access FSM with byte-lane steering and load extraction.
// Optional feature macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of reaching the bus.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALU_co_pype,
   input  logic [31:0] read_data2_pype2,
   input  logic [1:0]  dsize_pype2,
   input  logic [1:0]  MemRW_pype2,
   input  logic [2:0]  funct3_pype2,
   input  logic [4:0]  WReg_pype2,
   input  logic        RegWrite_pype2,
   input  logic [1:0]  MemtoReg_pype2,
   input  logic [31:0] PCp4_pype2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] ALU_co_pype3,
   output logic [31:0] load_data_pype3,
   output logic [4:0]  WReg_pype3,
   output logic        RegWrite_pype3,
   output logic [1:0]  MemtoReg_pype3,
   output logic [31:0] PCp4_pype3,
   output logic        mem_busy,
   output logic        misalign_err
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [31:0] r_pcp4;
   logic [1:0]  r_dsize;
   logic [1:0]  r_memtoreg;
   logic        r_store;
   logic        r_unsigned;
   logic [4:0]  r_wreg;
   logic        r_regwrite;

   logic        w_is_mem;
   logic        w_misalign;
   logic        w_start;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [1:0]  w_off;
   logic [31:0] w_shifted;
   logic [31:0] w_load_val;
   logic        w_unused;

   assign w_unused = ^funct3_pype2[1:0];
   assign w_is_mem = (MemRW_pype2 == 2'b01) || (MemRW_pype2 == 2'b10);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_misalign = w_is_mem &&
                       (((dsize_pype2 == 2'b01) && ALU_co_pype[0]) ||
                        (dsize_pype2[1] && (ALU_co_pype[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_start = w_is_mem && !w_misalign;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_data;
      if (r_store) begin
         case (r_dsize)
            2'b00: begin
               w_be    = 4'b0001 << r_addr[1:0];
               w_wdata = {4{r_data[7:0]}};
            end
            2'b01: begin
               w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{r_data[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = r_data;
            end
         endcase
      end
   end

   // Low address bits that cannot address a lane of this size are ignored.
   always_comb begin
      w_off = 2'b00;
      case (r_dsize)
         2'b00:   w_off = r_addr[1:0];
         2'b01:   w_off = {r_addr[1], 1'b0};
         default: w_off = 2'b00;
      endcase
      w_shifted = dmem_rdata >> {w_off, 3'b000};
      case (r_dsize)
         2'b00:   w_load_val = r_unsigned ? {24'b0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_load_val = r_unsigned ? {16'b0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load_val = w_shifted;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      mem_busy     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_be      = 4'b0000;
      dmem_addr    = 32'b0;
      dmem_wdata   = 32'b0;
      case (r_state)
         S_IDLE: begin
            mem_busy = w_start && !rst;
            if (w_start) begin
               w_next_state = S_BUSY;
            end
         end
         S_BUSY: begin
            mem_busy   = !rst;
            dmem_req   = 1'b1;
            dmem_we    = r_store;
            dmem_be    = w_be;
            dmem_addr  = {r_addr[31:2], 2'b00};
            dmem_wdata = w_wdata;
            if (dmem_ack) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      if (rst) begin
         w_next_state = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_addr          <= 32'b0;
         r_data          <= 32'b0;
         r_pcp4          <= 32'b0;
         r_dsize         <= 2'b0;
         r_memtoreg      <= 2'b0;
         r_store         <= 1'b0;
         r_unsigned      <= 1'b0;
         r_wreg          <= 5'b0;
         r_regwrite      <= 1'b0;
         ALU_co_pype3    <= 32'b0;
         load_data_pype3 <= 32'b0;
         WReg_pype3      <= 5'b0;
         RegWrite_pype3  <= 1'b0;
         MemtoReg_pype3  <= 2'b0;
         PCp4_pype3      <= 32'b0;
         misalign_err    <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         misalign_err <= (r_state == S_IDLE) && w_misalign;
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  RegWrite_pype3 <= 1'b0;
                  WReg_pype3     <= 5'b0;
                  if (w_start) begin
                     r_addr     <= ALU_co_pype;
                     r_data     <= read_data2_pype2;
                     r_pcp4     <= PCp4_pype2;
                     r_dsize    <= dsize_pype2;
                     r_memtoreg <= MemtoReg_pype2;
                     r_store    <= (MemRW_pype2 == 2'b10);
                     r_unsigned <= funct3_pype2[2];
                     r_wreg     <= WReg_pype2;
                     r_regwrite <= RegWrite_pype2;
                  end
               end else begin
                  ALU_co_pype3    <= ALU_co_pype;
                  load_data_pype3 <= 32'b0;
                  WReg_pype3      <= WReg_pype2;
                  RegWrite_pype3  <= RegWrite_pype2;
                  MemtoReg_pype3  <= MemtoReg_pype2;
                  PCp4_pype3      <= PCp4_pype2;
               end
            end
            S_BUSY: begin
               if (dmem_ack) begin
                  ALU_co_pype3    <= r_addr;
                  load_data_pype3 <= r_store ? 32'b0 : w_load_val;
                  WReg_pype3      <= r_wreg;
                  RegWrite_pype3  <= r_regwrite;
                  MemtoReg_pype3  <= r_memtoreg;
                  PCp4_pype3      <= r_pcp4;
               end else begin
                  RegWrite_pype3 <= 1'b0;
                  WReg_pype3     <= 5'b0;
               end
            end
            default: begin
               RegWrite_pype3 <= 1'b0;
               WReg_pype3     <= 5'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access against a lane-arithmetic reference model.
// Honours MEM_MISALIGN_TRAP_EN when the build defines it.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2;
   logic [1:0]  dsize_pype2, MemRW_pype2, MemtoReg_pype2;
   logic [2:0]  funct3_pype2;
   logic [4:0]  WReg_pype2;
   logic        RegWrite_pype2;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] ALU_co_pype3, load_data_pype3, PCp4_pype3;
   logic [4:0]  WReg_pype3;
   logic        RegWrite_pype3;
   logic [1:0]  MemtoReg_pype3;
   logic        mem_busy, misalign_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access dut (
      .clk(clk), .rst(rst),
      .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
      .dsize_pype2(dsize_pype2), .MemRW_pype2(MemRW_pype2), .funct3_pype2(funct3_pype2),
      .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
      .MemtoReg_pype2(MemtoReg_pype2), .PCp4_pype2(PCp4_pype2),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .ALU_co_pype3(ALU_co_pype3), .load_data_pype3(load_data_pype3),
      .WReg_pype3(WReg_pype3), .RegWrite_pype3(RegWrite_pype3),
      .MemtoReg_pype3(MemtoReg_pype3), .PCp4_pype3(PCp4_pype3),
      .mem_busy(mem_busy), .misalign_err(misalign_err)
   );

   function automatic logic [3:0] ref_be(input logic store, input logic [1:0] ds, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      if (!store || ds >= 2) return 4'hF;
      if (ds == 0) return 4'(1 << off);
      return (off >= 2) ? 4'hC : 4'h3;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] ds, input logic [31:0] d);
      if (ds == 0) return (d & 32'hFF) * 32'h0101_0101;
      if (ds == 1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] ds,
                                            input logic [2:0] f3, input logic [31:0] a);
      longint unsigned v, mask;
      int nbits, off;
      nbits = (ds == 0) ? 8 : (ds == 1) ? 16 : 32;
      off   = (ds == 0) ? int'(a % 4) : (ds == 1) ? int'((a % 4) / 2 * 2) : 0;
      mask  = (64'd1 << nbits) - 1;
      v     = {32'b0, rd};
      v     = (v >> (8 * off)) & mask;
      if (!f3[2] && (((v >> (nbits - 1)) & 1) == 1)) v = v | ~mask;
      return v[31:0];
   endfunction

   task automatic drive_op(input logic [1:0] rw, input logic [1:0] ds, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr,
                           input logic rwr, input logic [1:0] m2r, input logic [31:0] pc);
      MemRW_pype2 = rw; dsize_pype2 = ds; funct3_pype2 = f3; ALU_co_pype = a;
      read_data2_pype2 = d; WReg_pype2 = wr; RegWrite_pype2 = rwr;
      MemtoReg_pype2 = m2r; PCp4_pype2 = pc;
   endtask

   task automatic drive_nop();
      drive_op(2'b00, 2'b00, 3'b000, 32'b0, 32'b0, 5'b0, 1'b0, 2'b00, 32'b0);
   endtask

   // Issues one access, holds it (as a stalled upstream would), acks in BUSY cycle nbusy,
   // and reports what was observed on the bus. Returns #1 after the ack edge.
   task automatic run_mem(input logic [1:0] rw, input logic [1:0] ds, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr,
                          input logic rwr, input logic [1:0] m2r, input logic [31:0] pc,
                          input int nbusy, input logic [31:0] rd,
                          output int busy_cnt, output logic [31:0] bus_addr,
                          output logic [31:0] bus_wdata, output logic [3:0] bus_be,
                          output logic bus_we, output logic stable, output logic bubbles);
      @(negedge clk);
      drive_op(rw, ds, f3, a, d, wr, rwr, m2r, pc);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      #1 busy_cnt = int'(mem_busy);
      stable = 1'b1; bubbles = 1'b1;
      bus_addr = 32'b0; bus_wdata = 32'b0; bus_be = 4'b0; bus_we = 1'b0;
      @(posedge clk); #1;
      if (RegWrite_pype3 !== 1'b0 || WReg_pype3 !== 5'b0) bubbles = 1'b0;
      for (int k = 1; k <= nbusy; k++) begin
         @(negedge clk);
         dmem_ack   = (k == nbusy);
         dmem_rdata = (k == nbusy) ? rd : $urandom;
         #1 busy_cnt += int'(mem_busy);
         if (k == 1) begin
            bus_addr = dmem_addr; bus_wdata = dmem_wdata; bus_be = dmem_be; bus_we = dmem_we;
         end else if (dmem_addr !== bus_addr || dmem_wdata !== bus_wdata ||
                      dmem_be !== bus_be || dmem_we !== bus_we) begin
            stable = 1'b0;
         end
         if (dmem_req !== 1'b1) stable = 1'b0;
         @(posedge clk); #1;
         if (k < nbusy && (RegWrite_pype3 !== 1'b0 || WReg_pype3 !== 5'b0)) bubbles = 1'b0;
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = $urandom;
      @(negedge clk);
      drive_op(2'b01, 2'b10, 3'b000, $urandom, $urandom, 5'd7, 1'b1, 2'b01, $urandom);
      #1; total++;
      if (mem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", mem_busy); end
      @(posedge clk); #1; total++;
      if ({ALU_co_pype3, load_data_pype3, WReg_pype3, RegWrite_pype3, MemtoReg_pype3, PCp4_pype3, misalign_err} !== '0) begin
         bad++; $display("FAIL reset_mewb got alu=%h ld=%h wr=%0d rw=%0b mis=%0b exp=all zero",
                         ALU_co_pype3, load_data_pype3, WReg_pype3, RegWrite_pype3, misalign_err);
      end
      total++;
      if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin
         bad++; $display("FAIL reset_bus got req=%0b we=%0b be=%b exp=0 0 0000", dmem_req, dmem_we, dmem_be);
      end
      @(negedge clk); drive_nop(); rst = 1'b0;
   endtask

   task automatic test_nonmem();
      logic [31:0] a, pc;
      logic [4:0]  wr;
      logic        rwr;
      logic [1:0]  m2r, rw;
      for (int i = 0; i < 6; i++) begin
         a   = (i == 0) ? 32'h1234 : $urandom;
         wr  = (i == 0) ? 5'd5 : 5'($urandom);
         rwr = (i == 0) ? 1'b1 : 1'($urandom);
         m2r = 2'($urandom); pc = $urandom;
         rw  = (i % 2 == 0) ? 2'b00 : 2'b11;
         @(negedge clk);
         drive_op(rw, 2'($urandom), 3'($urandom), a, $urandom, wr, rwr, m2r, pc);
         dmem_ack = 1'($urandom);
         #1; total++;
         if (mem_busy !== 1'b0) begin bad++; $display("FAIL nonmem_busy[%0d] got=%0b exp=0", i, mem_busy); end
         @(posedge clk); #1; total++;
         if ({ALU_co_pype3, WReg_pype3, RegWrite_pype3, MemtoReg_pype3, PCp4_pype3, load_data_pype3} !==
             {a, wr, rwr, m2r, pc, 32'b0}) begin
            bad++; $display("FAIL nonmem_mewb[%0d] got alu=%h wr=%0d rw=%0b ld=%h exp alu=%h wr=%0d rw=%0b ld=0",
                            i, ALU_co_pype3, WReg_pype3, RegWrite_pype3, load_data_pype3, a, wr, rwr);
         end
         total++;
         if (dmem_req !== 1'b0) begin bad++; $display("FAIL nonmem_req[%0d] got=%0b exp=0", i, dmem_req); end
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_store_byte();
      int cnt; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, st, bub;
      run_mem(2'b10, 2'b00, 3'b000, 32'h1003, 32'h0000_00AB, 5'd3, 1'b0, 2'b00, 32'h44,
              3, $urandom, cnt, ba, bw, bb, bwe, st, bub);
      total++; if (cnt !== 4) begin bad++; $display("FAIL sb_busy_cycles got=%0d exp=4", cnt); end
      total++; if (bb !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", bb); end
      total++; if (bw !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=ababab ab", bw); end
      total++; if (bwe !== 1'b1) begin bad++; $display("FAIL sb_we got=%0b exp=1", bwe); end
      total++; if (ba !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", ba); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL sb_stable got=%0b exp=1", st); end
      total++; if (bub !== 1'b1) begin bad++; $display("FAIL sb_bubbles got=%0b exp=1", bub); end
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL sb_req_after got=%0b exp=0", dmem_req); end
   endtask

   task automatic test_load_half();
      int cnt; logic [31:0] ba, bw; logic [3:0] bb; logic bwe, st, bub;
      run_mem(2'b01, 2'b01, 3'b001, 32'h2002, 32'b0, 5'd11, 1'b1, 2'b01, 32'h80,
              1, 32'h8001_0000, cnt, ba, bw, bb, bwe, st, bub);
      total++; if (load_data_pype3 !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_signed got=%h exp=ffff8001", load_data_pype3); end
      total++; if ({WReg_pype3, RegWrite_pype3} !== {5'd11, 1'b1}) begin bad++; $display("FAIL lh_wreg got=%0d/%0b exp=11/1", WReg_pype3, RegWrite_pype3); end
      total++; if (bb !== 4'b1111 || bwe !== 1'b0) begin bad++; $display("FAIL lh_be_we got=%b/%0b exp=1111/0", bb, bwe); end
      run_mem(2'b01, 2'b01, 3'b101, 32'h2002, 32'b0, 5'd12, 1'b1, 2'b01, 32'h84,
              2, 32'h8001_0000, cnt, ba, bw, bb, bwe, st, bub);
      total++; if (load_data_pype3 !== 32'h0000_8001) begin bad++; $display("FAIL lhu_unsigned got=%h exp=00008001", load_data_pype3); end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      drive_op(2'b01, 2'b10, 3'b000, 32'h4000, 32'b0, 5'd9, 1'b1, 2'b01, 32'h100);
      dmem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1; total++;
      if (dmem_req !== 1'b1) begin bad++; $display("FAIL rb_req_busy2 got=%0b exp=1", dmem_req); end
      rst = 1'b1;
      #1; total++;
      if (mem_busy !== 1'b0) begin bad++; $display("FAIL rb_busy_in_reset got=%0b exp=0", mem_busy); end
      @(posedge clk); #1; total++;
      if ({dmem_req, ALU_co_pype3, RegWrite_pype3, WReg_pype3, load_data_pype3, PCp4_pype3} !== '0) begin
         bad++; $display("FAIL rb_after_reset got req=%0b alu=%h rw=%0b exp=all zero", dmem_req, ALU_co_pype3, RegWrite_pype3);
      end
      @(negedge clk);
      rst = 1'b0; drive_nop(); dmem_ack = 1'b1; dmem_rdata = $urandom;
      @(posedge clk); #1; total++;
      if ({dmem_req, RegWrite_pype3, WReg_pype3, load_data_pype3, ALU_co_pype3} !== '0) begin
         bad++; $display("FAIL rb_late_ack got req=%0b rw=%0b wr=%0d ld=%h exp=all zero",
                         dmem_req, RegWrite_pype3, WReg_pype3, load_data_pype3);
      end
      dmem_ack = 1'b0;
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
      @(negedge clk);
      drive_op(2'b01, 2'b10, 3'b000, 32'h3002, 32'b0, 5'd4, 1'b1, 2'b01, 32'h8);
      dmem_ack = 1'b0;
      #1; total++;
      if (mem_busy !== 1'b0) begin bad++; $display("FAIL mis_busy got=%0b exp=0", mem_busy); end
      @(posedge clk); #1; total++;
      if ({misalign_err, RegWrite_pype3, dmem_req} !== 3'b100) begin
         bad++; $display("FAIL mis_trap got err=%0b rw=%0b req=%0b exp=1 0 0", misalign_err, RegWrite_pype3, dmem_req);
      end
      @(negedge clk); drive_nop();
      @(posedge clk); #1; total++;
      if ({misalign_err, dmem_req} !== 2'b00) begin
         bad++; $display("FAIL mis_pulse_end got err=%0b req=%0b exp=0 0", misalign_err, dmem_req);
      end
`else
      int cnt; logic [31:0] ba, bw, rd; logic [3:0] bb; logic bwe, st, bub;
      rd = $urandom;
      run_mem(2'b01, 2'b10, 3'b000, 32'h3002, 32'b0, 5'd4, 1'b1, 2'b01, 32'h8,
              2, rd, cnt, ba, bw, bb, bwe, st, bub);
      total++; if (ba !== 32'h3000) begin bad++; $display("FAIL mis_addr got=%h exp=00003000", ba); end
      total++; if (bb !== 4'b1111) begin bad++; $display("FAIL mis_be got=%b exp=1111", bb); end
      total++; if (load_data_pype3 !== rd) begin bad++; $display("FAIL mis_load got=%h exp=%h", load_data_pype3, rd); end
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_err_tied got=%0b exp=0", misalign_err); end
`endif
   endtask

   task automatic test_back_to_back();
      int cnt, t0; logic [31:0] ba, bw, a, rd; logic [3:0] bb; logic bwe, st, bub;
      logic [1:0] ds; logic [2:0] f3;
      @(negedge clk); drive_nop();
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 2; i++) begin
         a = {18'b0, 14'($urandom)}; ds = 2'(i); f3 = 3'($urandom); rd = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
         if (ds == 2'b01) a[0] = 1'b0;
`endif
         run_mem(2'b01, ds, f3, a, 32'b0, 5'(20 + i), 1'b1, 2'b01, 32'(i),
                 1, rd, cnt, ba, bw, bb, bwe, st, bub);
         total++; if (cnt !== 2) begin bad++; $display("FAIL b2b_busy[%0d] got=%0d exp=2", i, cnt); end
         total++;
         if ({load_data_pype3, WReg_pype3, PCp4_pype3} !== {ref_load(rd, ds, f3, a), 5'(20 + i), 32'(i)}) begin
            bad++; $display("FAIL b2b_result[%0d] got ld=%h wr=%0d exp ld=%h wr=%0d",
                            i, load_data_pype3, WReg_pype3, ref_load(rd, ds, f3, a), 20 + i);
         end
      end
      total++; if (cyc - t0 !== 4) begin bad++; $display("FAIL b2b_cycles got=%0d exp=4", cyc - t0); end
   endtask

   task automatic test_random();
      int cnt, nb; logic [31:0] ba, bw, a, d, rd, pc, exp_ld; logic [3:0] bb; logic bwe, st, bub;
      logic [1:0] rw, ds, m2r; logic [2:0] f3; logic [4:0] wr; logic rwr, store;
      for (int i = 0; i < 30; i++) begin
         rw = ($urandom_range(0, 3) == 0) ? 2'b00 : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
         ds = 2'($urandom); f3 = 3'($urandom); a = $urandom; d = $urandom; rd = $urandom;
         wr = 5'($urandom); rwr = 1'($urandom); m2r = 2'($urandom); pc = $urandom;
         nb = $urandom_range(1, 4);
`ifdef MEM_MISALIGN_TRAP_EN
         if (ds == 2'b01) a[0] = 1'b0;
         if (ds[1]) a[1:0] = 2'b00;
`endif
         if (rw == 2'b00) begin
            @(negedge clk);
            drive_op(rw, ds, f3, a, d, wr, rwr, m2r, pc);
            @(posedge clk); #1; total++;
            if ({ALU_co_pype3, WReg_pype3, RegWrite_pype3, load_data_pype3} !== {a, wr, rwr, 32'b0}) begin
               bad++; $display("FAIL rnd_nonmem[%0d] got alu=%h wr=%0d exp alu=%h wr=%0d", i, ALU_co_pype3, WReg_pype3, a, wr);
            end
            continue;
         end
         store  = (rw == 2'b10);
         exp_ld = store ? 32'b0 : ref_load(rd, ds, f3, a);
         run_mem(rw, ds, f3, a, d, wr, rwr, m2r, pc, nb, rd, cnt, ba, bw, bb, bwe, st, bub);
         total++;
         if (cnt !== nb + 1 || st !== 1'b1 || bub !== 1'b1) begin
            bad++; $display("FAIL rnd_timing[%0d] got busy=%0d stable=%0b bub=%0b exp busy=%0d 1 1", i, cnt, st, bub, nb + 1);
         end
         total++;
         if ({ba, bb, bwe} !== {a & 32'hFFFF_FFFC, ref_be(store, ds, a), store}) begin
            bad++; $display("FAIL rnd_bus[%0d] got addr=%h be=%b we=%0b exp addr=%h be=%b we=%0b",
                            i, ba, bb, bwe, a & 32'hFFFF_FFFC, ref_be(store, ds, a), store);
         end
         if (store) begin
            total++;
            if (bw !== ref_wdata(ds, d)) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, bw, ref_wdata(ds, d)); end
         end
         total++;
         if ({ALU_co_pype3, load_data_pype3, WReg_pype3, RegWrite_pype3, MemtoReg_pype3, PCp4_pype3, dmem_req} !==
             {a, exp_ld, wr, rwr, m2r, pc, 1'b0}) begin
            bad++; $display("FAIL rnd_mewb[%0d] got alu=%h ld=%h wr=%0d req=%0b exp alu=%h ld=%h wr=%0d req=0",
                            i, ALU_co_pype3, load_data_pype3, WReg_pype3, dmem_req, a, exp_ld, wr);
         end
      end
   endtask

   initial begin
      drive_nop();
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'b0;
      test_reset();
      test_nonmem();
      test_store_byte();
      test_load_half();
      test_reset_busy();
      test_misalign();
      test_back_to_back();
      test_random();
      @(negedge clk); drive_nop();
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
